// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the memory port
// arbiter. The arbiter uses the slave view; the pipeline/memory side uses master.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  // MEM-stage load/store port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [2:0]        d_func3;
  logic              d_ready;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  // unified memory port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_func3;
  logic [DATA_W-1:0] mem_rdata;
  // pipeline freeze controls
  logic              stall_if;
  logic              stall_mem;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_func3, mem_rdata,
    output if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_func3, stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_func3, mem_rdata,
    input  if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_func3, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and the
// MEM-stage load/store. One transaction in flight; data wins unless the fetch
// has been passed over STARVE_MAX times in a row.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  state_t            state_q;
  logic [3:0]        lat_cnt_q;
  logic [SW-1:0]     starve_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        func3_q;
  logic              we_q;

  logic              sel_d;
  logic              sel_if;
  logic              busy;
  logic              done;
  logic              starved;
  logic [SW-1:0]     starve_d;

  // Grant decision in IDLE plus transaction-completion detect; everything is
  // masked while reset is asserted so outputs read 0 during reset.
  always_comb begin
    starved  = (starve_q == SW'(STARVE_MAX));
    sel_d    = rst && (state_q == IDLE) && bus.d_req && !(bus.if_req && starved);
    sel_if   = rst && (state_q == IDLE) && !sel_d && bus.if_req;
    busy     = rst && (state_q != IDLE);
    done     = busy && (lat_cnt_q == 4'(MEM_LAT));
    // data grant with fetch waiting bumps the count (saturating); otherwise clear
    starve_d = '0;
    if (bus.if_req && !starved) starve_d = starve_q + SW'(1);
    else if (bus.if_req)        starve_d = starve_q;
  end

  // Arbitration FSM: captures the winner's request and counts memory latency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      lat_cnt_q <= '0;
      starve_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      func3_q   <= '0;
      we_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_d) begin
            state_q   <= BUSY_D;
            lat_cnt_q <= 4'd1;
            starve_q  <= starve_d;
            addr_q    <= bus.d_addr;
            wdata_q   <= bus.d_wdata;
            func3_q   <= bus.d_func3;
            we_q      <= bus.d_we;
          end else if (sel_if) begin
            state_q   <= BUSY_IF;
            lat_cnt_q <= 4'd1;
            starve_q  <= '0;
            addr_q    <= bus.if_addr;
            wdata_q   <= '0;
            func3_q   <= 3'b010;  // fetches are always full words
            we_q      <= 1'b0;
          end
        end
        BUSY_IF, BUSY_D: begin
          if (lat_cnt_q == 4'(MEM_LAT)) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
          end else begin
            lat_cnt_q <= lat_cnt_q + 4'd1;
          end
        end
        default: begin
          state_q   <= IDLE;
          lat_cnt_q <= '0;
        end
      endcase
    end
  end

  // Issue cycle presents the winner directly; while busy the captured copy is held.
  assign bus.if_ready  = sel_if;
  assign bus.d_ready   = sel_d;
  assign bus.mem_en    = sel_d | sel_if;
  assign bus.mem_we    = sel_d ? bus.d_we : (busy ? we_q : 1'b0);
  assign bus.mem_addr  = sel_d ? bus.d_addr  : sel_if ? bus.if_addr : busy ? addr_q  : '0;
  assign bus.mem_wdata = sel_d ? bus.d_wdata : sel_if ? '0          : busy ? wdata_q : '0;
  assign bus.mem_func3 = sel_d ? bus.d_func3 : sel_if ? 3'b010      : busy ? func3_q : 3'b000;

  // Response routing: only the owner of the finishing transaction sees rvalid.
  assign bus.if_rvalid = done && (state_q == BUSY_IF);
  assign bus.d_rvalid  = done && (state_q == BUSY_D);
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
  assign bus.d_rdata   = (bus.d_rvalid && !we_q) ? bus.mem_rdata : '0;

  assign bus.stall_if  = rst && bus.if_req && !bus.if_rvalid;
  assign bus.stall_mem = rst && bus.d_req  && !bus.d_rvalid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, lone fetch, contention,
// starvation guard, reset mid-transaction and MEM_LAT=1 back-to-back loads.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut_lat1 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  int chk_pass  = 0;
  int chk_total = 0;

  // drive point: just after the rising edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // sample point: falling edge, away from the active edge
  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus1.if_req = 0; bus1.if_addr = '0; bus1.d_req = 0; bus1.d_we = 0;
    bus1.d_addr = '0; bus1.d_wdata = '0; bus1.d_func3 = '0; bus1.mem_rdata = '0;
    bus2.if_req = 0; bus2.if_addr = '0; bus2.d_req = 0; bus2.d_we = 0;
    bus2.d_addr = '0; bus2.d_wdata = '0; bus2.d_func3 = '0; bus2.mem_rdata = '0;
  endtask

  task automatic test_reset();
    logic [6:0] flags;
    bus1.if_req = 1; bus1.d_req = 1; bus1.if_addr = 32'h10; bus1.d_addr = 32'h20;
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      sample();
      flags = {bus1.mem_en, bus1.if_ready, bus1.d_ready, bus1.stall_if,
               bus1.stall_mem, bus1.if_rvalid, bus1.d_rvalid};
      chk_total++;
      if (flags !== 7'b0) $display("FAIL reset_outputs c%0d: flags=%b expected 0000000", c, flags);
      else chk_pass++;
      chk_total++;
      if (bus1.mem_addr !== 32'h0) $display("FAIL reset_addr c%0d: mem_addr=%h expected 0", c, bus1.mem_addr);
      else chk_pass++;
    end
    next_cycle();
    rst = 1;
    sample();
    chk_total++;
    if ({bus1.mem_en, bus1.d_ready, bus1.if_ready} !== 3'b110)
      $display("FAIL reset_first_issue: en/d_ready/if_ready=%b expected 110",
               {bus1.mem_en, bus1.d_ready, bus1.if_ready});
    else chk_pass++;
    next_cycle();
    bus1.if_req = 0; bus1.d_req = 0;
    repeat (3) next_cycle();
    $display("test_reset done");
  endtask

  task automatic test_lone_fetch();
    bus1.if_req = 1; bus1.if_addr = 32'h40; bus1.mem_rdata = 32'h00500093;
    sample();  // t0
    chk_total++;
    if ({bus1.if_ready, bus1.mem_en, bus1.mem_we, bus1.stall_if} !== 4'b1101)
      $display("FAIL fetch_issue: ready/en/we/stall=%b expected 1101",
               {bus1.if_ready, bus1.mem_en, bus1.mem_we, bus1.stall_if});
    else chk_pass++;
    chk_total++;
    if (bus1.mem_addr !== 32'h40) $display("FAIL fetch_addr_t0: mem_addr=%h expected 00000040", bus1.mem_addr);
    else chk_pass++;
    next_cycle(); bus1.if_req = 0;
    sample();  // t1
    chk_total++;
    if ({bus1.if_rvalid, bus1.mem_en} !== 2'b00 || bus1.mem_addr !== 32'h40)
      $display("FAIL fetch_hold_t1: rvalid/en=%b addr=%h expected 00 / 00000040",
               {bus1.if_rvalid, bus1.mem_en}, bus1.mem_addr);
    else chk_pass++;
    next_cycle();
    sample();  // t2
    chk_total++;
    if (bus1.if_rvalid !== 1'b1 || bus1.if_rdata !== 32'h00500093)
      $display("FAIL fetch_rvalid_t2: rvalid=%b rdata=%h expected 1 / 00500093",
               bus1.if_rvalid, bus1.if_rdata);
    else chk_pass++;
    next_cycle();
    $display("test_lone_fetch done");
  endtask

  task automatic test_contention();
    bus1.if_req = 1; bus1.if_addr = 32'h44;
    bus1.d_req = 1; bus1.d_we = 1; bus1.d_addr = 32'h100; bus1.d_wdata = 32'hDEADBEEF;
    bus1.d_func3 = 3'b010; bus1.mem_rdata = 32'h12345678;
    sample();  // t0
    chk_total++;
    if ({bus1.d_ready, bus1.if_ready, bus1.mem_we} !== 3'b101 ||
        bus1.mem_addr !== 32'h100 || bus1.mem_wdata !== 32'hDEADBEEF)
      $display("FAIL cont_issue_t0: d_rdy/if_rdy/we=%b addr=%h wdata=%h expected 101 / 00000100 / deadbeef",
               {bus1.d_ready, bus1.if_ready, bus1.mem_we}, bus1.mem_addr, bus1.mem_wdata);
    else chk_pass++;
    next_cycle(); bus1.d_req = 0; bus1.d_we = 0; bus1.d_wdata = '0;
    sample();  // t1
    chk_total++;
    if (bus1.mem_wdata !== 32'hDEADBEEF || bus1.mem_func3 !== 3'b010 || bus1.if_ready !== 1'b0)
      $display("FAIL cont_hold_t1: wdata=%h func3=%0d if_ready=%b expected deadbeef / 2 / 0",
               bus1.mem_wdata, bus1.mem_func3, bus1.if_ready);
    else chk_pass++;
    next_cycle();
    sample();  // t2
    chk_total++;
    if ({bus1.d_rvalid, bus1.stall_if} !== 2'b11 || bus1.d_rdata !== 32'h0)
      $display("FAIL cont_store_done_t2: d_rvalid/stall_if=%b d_rdata=%h expected 11 / 00000000",
               {bus1.d_rvalid, bus1.stall_if}, bus1.d_rdata);
    else chk_pass++;
    next_cycle();
    sample();  // t3
    chk_total++;
    if (bus1.if_ready !== 1'b1 || bus1.mem_addr !== 32'h44)
      $display("FAIL cont_fetch_t3: if_ready=%b addr=%h expected 1 / 00000044",
               bus1.if_ready, bus1.mem_addr);
    else chk_pass++;
    next_cycle(); bus1.if_req = 0;
    next_cycle();
    sample();  // t5
    chk_total++;
    if (bus1.if_rvalid !== 1'b1 || bus1.if_rdata !== 32'h12345678)
      $display("FAIL cont_fetch_rvalid_t5: rvalid=%b rdata=%h expected 1 / 12345678",
               bus1.if_rvalid, bus1.if_rdata);
    else chk_pass++;
    next_cycle();
    $display("test_contention done");
  endtask

  task automatic test_starvation();
    logic [1:0] got;
    logic [1:0] exp;
    bus1.if_req = 1; bus1.if_addr = 32'h80; bus1.d_req = 1; bus1.d_we = 0; bus1.d_addr = 32'h180;
    for (int c = 0; c < 16; c++) begin
      sample();
      got = {bus1.if_ready, bus1.d_ready};
      exp = (c == 12) ? 2'b10 : ((c % 3 == 0) ? 2'b01 : 2'b00);
      chk_total++;
      if (got !== exp) $display("FAIL starve_c%0d: {if_ready,d_ready}=%b expected %b", c, got, exp);
      else chk_pass++;
      next_cycle();
    end
    bus1.if_req = 0; bus1.d_req = 0;
    repeat (3) next_cycle();
    $display("test_starvation done");
  endtask

  task automatic test_reset_mid();
    bus1.d_req = 1; bus1.d_we = 0; bus1.d_addr = 32'h200; bus1.mem_rdata = 32'hCAFEF00D;
    sample();  // t0
    chk_total++;
    if (bus1.d_ready !== 1'b1) $display("FAIL rmid_issue_t0: d_ready=%b expected 1", bus1.d_ready);
    else chk_pass++;
    next_cycle(); bus1.d_req = 0; rst = 0;
    sample();  // t1
    chk_total++;
    if ({bus1.d_rvalid, bus1.mem_en, bus1.stall_mem} !== 3'b000)
      $display("FAIL rmid_in_reset_t1: rvalid/en/stall=%b expected 000",
               {bus1.d_rvalid, bus1.mem_en, bus1.stall_mem});
    else chk_pass++;
    next_cycle(); rst = 1; bus1.d_req = 1; bus1.d_addr = 32'h300;
    sample();  // t2
    chk_total++;
    if ({bus1.d_rvalid, bus1.d_ready} !== 2'b01 || bus1.mem_addr !== 32'h300)
      $display("FAIL rmid_regrant_t2: rvalid/ready=%b addr=%h expected 01 / 00000300",
               {bus1.d_rvalid, bus1.d_ready}, bus1.mem_addr);
    else chk_pass++;
    next_cycle(); bus1.d_req = 0;
    repeat (3) next_cycle();
    $display("test_reset_mid done");
  endtask

  task automatic test_back_to_back();
    logic [2:0] got;
    logic [2:0] exp;
    bus2.d_req = 1; bus2.d_we = 0; bus2.d_addr = 32'h400;
    for (int c = 0; c < 8; c++) begin
      bus2.mem_rdata = 32'hA5A50000 + 32'(c);
      sample();
      got = {bus2.d_ready, bus2.d_rvalid, bus2.stall_mem};
      exp = (c % 2 == 0) ? 3'b101 : 3'b010;
      chk_total++;
      if (got !== exp) $display("FAIL b2b_c%0d: {d_ready,d_rvalid,stall_mem}=%b expected %b", c, got, exp);
      else chk_pass++;
      if (c % 2 == 1) begin
        chk_total++;
        if (bus2.d_rdata !== 32'hA5A50000 + 32'(c))
          $display("FAIL b2b_rdata_c%0d: d_rdata=%h expected %h", c, bus2.d_rdata, 32'hA5A50000 + 32'(c));
        else chk_pass++;
      end
      next_cycle();
    end
    bus2.d_req = 0;
    repeat (2) next_cycle();
    $display("test_back_to_back done");
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_lone_fetch();
    test_contention();
    test_starvation();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end
endmodule
